upscale: RTL and testbench

//  Converts a valid/ready stream of signed IMG_WIDTH image samples into signed NUM_WIDTH MAC/ADD numbers.

---
 rtl/upscale_pkg.sv | 20 ++
 rtl/upscale_pipe_stage.sv | 44 ++++
 rtl/upscale.sv | 135 +++++++++++++
 tb/tb_upscale.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/upscale_pkg.sv
// Shared definitions for the upscale stage: width defaults, frame FSM states,
// image sample limits and the shift clamp helper.
package upscale_pkg;

  localparam int NUM_WIDTH_DEF = 33;
  localparam int IMG_WIDTH_DEF = 16;

  localparam logic [IMG_WIDTH_DEF-1:0] IMG_MAX = {1'b0, {(IMG_WIDTH_DEF-1){1'b1}}};
  localparam logic [IMG_WIDTH_DEF-1:0] IMG_MIN = {1'b1, {(IMG_WIDTH_DEF-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_e;

  function automatic logic [7:0] clamp_shift(input logic [7:0] s, input logic [7:0] smax);
    return (s > smax) ? smax : s;
  endfunction

endpackage

// File: rtl/upscale_pipe_stage.sv
// Generic valid/ready register slice carrying a data word and a last flag.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_val_i,
  output logic         in_rdy_o,
  input  logic         in_last_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_val_o,
  input  logic         out_rdy_i,
  output logic         out_last_o,
  output logic [W-1:0] out_data_o
);

  logic         val_q;
  logic         last_q;
  logic [W-1:0] data_q;
  logic         en;

  // The slice can load whenever it is empty or its contents leave this cycle.
  assign en       = ~val_q | out_rdy_i;
  assign in_rdy_o = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else if (en) begin
      val_q <= in_val_i;
      if (in_val_i) begin
        last_q <= in_last_i;
        data_q <= in_data_i;
      end
    end
  end

  assign out_val_o  = val_q;
  assign out_last_o = last_q;
  assign out_data_o = data_q;

endmodule

// File: rtl/upscale.sv
// Signed image sample -> signed MAC/ADD number: sign-extend (optional bias), clamped left shift.
// Optional feature macro: UPSCALE_BIAS_EN (bias subtraction before the shift).
module upscale
  import upscale_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF,
  parameter int IMG_WIDTH = IMG_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           shift,
  input  logic [IMG_WIDTH-1:0] bias,
  input  logic                 up_val,
  output logic                 up_rdy,
  input  logic                 up_last,
  input  logic [IMG_WIDTH-1:0] up_data,
  output logic                 dn_val,
  input  logic                 dn_rdy,
  output logic                 dn_last,
  output logic [NUM_WIDTH-1:0] dn_data
);

`ifdef UPSCALE_BIAS_EN
  localparam int XW        = IMG_WIDTH + 1;
  localparam int SHIFT_MAX = NUM_WIDTH - IMG_WIDTH - 1;
`else
  localparam int XW        = IMG_WIDTH;
  localparam int SHIFT_MAX = NUM_WIDTH - IMG_WIDTH;
`endif
  localparam logic [7:0] SHIFT_MAX_L = 8'(SHIFT_MAX);
  localparam int S1W = 8 + XW;

  state_e         state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     cur_shift;
  logic [XW-1:0]  x;
  logic           accept;

  logic           s1_val, s1_last, s2_rdy;
  logic [S1W-1:0] s1_in, s1_data;
  logic [7:0]     s1_sh;
  logic [XW-1:0]  s1_x;
  logic [NUM_WIDTH-1:0] res;

`ifdef UPSCALE_BIAS_EN
  logic [IMG_WIDTH-1:0] bias_q, bias_d, cur_bias;
`else
  logic unused_bias;
  assign unused_bias = ^bias;
`endif

  assign accept = up_val & up_rdy;

  // The first beat of a frame uses the live shift/bias while they are captured for the rest.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cur_shift = shift_q;
`ifdef UPSCALE_BIAS_EN
    bias_d    = bias_q;
    cur_bias  = bias_q;
`endif
    if (state_q == ST_IDLE) begin
      cur_shift = shift;
`ifdef UPSCALE_BIAS_EN
      cur_bias  = bias;
`endif
      if (accept) begin
        shift_d = shift;
`ifdef UPSCALE_BIAS_EN
        bias_d  = bias;
`endif
        if (!up_last) state_d = ST_FRAME;
      end
    end else begin
      if (accept && up_last) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
`ifdef UPSCALE_BIAS_EN
      bias_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
`ifdef UPSCALE_BIAS_EN
      bias_q  <= bias_d;
`endif
    end
  end

`ifdef UPSCALE_BIAS_EN
  assign x = {up_data[IMG_WIDTH-1], up_data} - {cur_bias[IMG_WIDTH-1], cur_bias};
`else
  assign x = up_data;
`endif

  // The clamped shift travels with its sample so frame boundaries cannot skew it.
  assign s1_in = {clamp_shift(cur_shift, SHIFT_MAX_L), x};

  pipe_stage #(.W(S1W)) u_p1 (
    .clk        (clk),
    .rst        (rst),
    .in_val_i   (up_val),
    .in_rdy_o   (up_rdy),
    .in_last_i  (up_last),
    .in_data_i  (s1_in),
    .out_val_o  (s1_val),
    .out_rdy_i  (s2_rdy),
    .out_last_o (s1_last),
    .out_data_o (s1_data)
  );

  assign s1_sh = s1_data[S1W-1:XW];
  assign s1_x  = s1_data[XW-1:0];
  assign res   = {{(NUM_WIDTH-XW){s1_x[XW-1]}}, s1_x} << s1_sh;

  pipe_stage #(.W(NUM_WIDTH)) u_p2 (
    .clk        (clk),
    .rst        (rst),
    .in_val_i   (s1_val),
    .in_rdy_o   (s2_rdy),
    .in_last_i  (s1_last),
    .in_data_i  (res),
    .out_val_o  (dn_val),
    .out_rdy_i  (dn_rdy),
    .out_last_o (dn_last),
    .out_data_o (dn_data)
  );

endmodule

// File: tb/tb_upscale.sv
// Directed self-checking bench for upscale (default 33/16 widths).
module tb_upscale;
  import upscale_pkg::*;

  localparam int NW = 33;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    shift;
  logic [IW-1:0] bias;
  logic          up_val, up_rdy, up_last;
  logic [IW-1:0] up_data;
  logic          dn_val, dn_rdy, dn_last;
  logic [NW-1:0] dn_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [NW:0]   got_q[$];
  logic          stall_prev = 1'b0;
  logic [NW-1:0] held_data;
  logic          held_last;
  int unsigned   stab_err = 0;
  int unsigned   rdy_err = 0;
  logic          rdy_low_seen = 1'b0;

  always #5 clk = ~clk;

  upscale #(.NUM_WIDTH(NW), .IMG_WIDTH(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .shift   (shift),
    .bias    (bias),
    .up_val  (up_val),
    .up_rdy  (up_rdy),
    .up_last (up_last),
    .up_data (up_data),
    .dn_val  (dn_val),
    .dn_rdy  (dn_rdy),
    .dn_last (dn_last),
    .dn_data (dn_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor: samples away from the rising edge; dn_rdy is only changed just after it.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && (dn_val !== 1'b1 || dn_data !== held_data || dn_last !== held_last))
        stab_err++;
      if (dn_val && !dn_rdy) begin
        stall_prev = 1'b1;
        held_data  = dn_data;
        held_last  = dn_last;
      end else begin
        stall_prev = 1'b0;
      end
      if (!up_rdy && dn_rdy) rdy_err++;
      if (!up_rdy) rdy_low_seen = 1'b1;
      if (dn_val && dn_rdy) got_q.push_back({dn_last, dn_data});
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [IW-1:0] d, input logic [7:0] s, input logic last);
    logic acc;
    int unsigned n;
    up_val  = 1'b1;
    up_data = d;
    shift   = s;
    up_last = last;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 30) begin
      @(negedge clk);
      acc = up_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    up_val = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [NW-1:0] d, input logic l);
    int unsigned n;
    logic [NW:0] item;
    n = 0;
    while (got_q.size() == 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      item = got_q.pop_front();
      check({tag, "_data"}, 64'(item[NW-1:0]), 64'(d));
      check({tag, "_last"}, 64'(item[NW]), 64'(l));
    end
  endtask

  initial begin
    rst = 1'b1; shift = '0; bias = '0; up_val = 1'b0; up_last = 1'b0; up_data = '0; dn_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dn_val",  64'(dn_val),  64'd0);
    check("rst_dn_last", 64'(dn_last), 64'd0);
    check("rst_dn_data", 64'(dn_data), 64'd0);
    check("rst_up_rdy",  64'(up_rdy),  64'd1);
    sync();
    rst = 1'b0;
    sync();

    // 1: latency and max positive sample
    send(IMG_MAX, 8'd8, 1'b1);
    @(negedge clk);
    check("t1_early_val", 64'(dn_val), 64'd0);
    @(negedge clk);
    check("t1_val",  64'(dn_val),  64'd1);
    check("t1_data", 64'(dn_data), 64'h0_007F_FF00);
    check("t1_last", 64'(dn_last), 64'd1);
    sync();
    got_q.delete();

    // 2/3: sign handling and shift clamp
    send(IMG_MIN,   8'd0,   1'b1);
    send(16'hFFFF,  8'd17,  1'b1);
    send(16'h0001,  8'd40,  1'b1);
    send(16'h8000,  8'd255, 1'b1);
    send(16'h7FFF,  8'd17,  1'b1);
    expect_out("t2_min",    33'h1_FFFF_8000, 1'b1);
    expect_out("t2_neg1",   33'h1_FFFE_0000, 1'b1);
    expect_out("t3_clamp",  33'h0_0002_0000, 1'b1);
    expect_out("t3_minmax", 33'h1_0000_0000, 1'b1);
    expect_out("t3_maxmax", 33'h0_FFFE_0000, 1'b1);
    sync();

    // 4: frame capture of shift
    send(16'h0003, 8'd2, 1'b0);
    send(16'h0005, 8'd5, 1'b0);
    send(16'hFFFE, 8'd5, 1'b0);
    send(16'h0100, 8'd5, 1'b1);
    send(16'h0003, 8'd5, 1'b1);
    expect_out("t4_b0",  33'h0_0000_000C, 1'b0);
    expect_out("t4_b1",  33'h0_0000_0014, 1'b0);
    expect_out("t4_b2",  33'h1_FFFF_FFF8, 1'b0);
    expect_out("t4_b3",  33'h0_0000_0400, 1'b1);
    expect_out("t4_nxt", 33'h0_0000_0060, 1'b1);
    sync();

    // 5: 10-beat stream with downstream stall
    rdy_low_seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(16'(i + 1), 8'd1, (i == 9));
      end
      begin
        for (int c = 0; c < 12; c++) begin
          dn_rdy = !(c >= 3 && c <= 7);
          sync();
        end
        dn_rdy = 1'b1;
      end
    join
    for (int i = 0; i < 10; i++)
      expect_out($sformatf("t5_b%0d", i), NW'(2 * (i + 1)), (i == 9));
    check("t5_rdy_low_seen", 64'(rdy_low_seen), 64'd1);
    check("t5_stable",       64'(stab_err),     64'd0);
    check("t5_rdy_rule",     64'(rdy_err),      64'd0);
    sync();

    // 6: reset with two beats held mid-frame
    dn_rdy = 1'b0;
    send(16'h0011, 8'd3, 1'b0);
    send(16'h0022, 8'd3, 1'b0);
    @(negedge clk);
    check("t6_full_val", 64'(dn_val), 64'd1);
    check("t6_full_rdy", 64'(up_rdy), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("t6_async_val",  64'(dn_val),  64'd0);
    check("t6_async_data", 64'(dn_data), 64'd0);
    sync();
    rst = 1'b0;
    dn_rdy = 1'b1;
    got_q.delete();
    sync();
    send(16'h0007, 8'd1, 1'b1);
    expect_out("t6_after", 33'h0_0000_000E, 1'b1);
    check("t6_no_extra", 64'(got_q.size()), 64'd0);
    sync();

    // 7: bias handling
    bias = 16'h0010;
`ifdef UPSCALE_BIAS_EN
    send(16'h0000, 8'd4, 1'b1);
    expect_out("t7_bias", 33'h1_FFFF_FF00, 1'b1);
`else
    send(16'h0001, 8'd4, 1'b1);
    expect_out("t7_nobias", 33'h0_0000_0010, 1'b1);
`endif
    sync();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
